// File: rtl/stage_mem_pkg.sv
// Shared definitions for the memory-access stage.
// Contents: funct3 load/store encodings, default bubble instruction,
// FSM state codes, access-size decode helper and the write-back bundle type.
package stage_mem_pkg;

    // addi x0,x0,0: what write-back sees for a bubble
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    // Load encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Bus sequencer states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    // Everything the write-back stage consumes, registered as one bundle
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instruction;
        logic [2:0]  funct3;
        logic [31:0] alu_d;
        logic [31:0] mem_d;
        logic [31:0] mem_addr;
        logic        is_ld;
        logic        ld_mis;
        logic        st_mis;
        logic        illegal;
        logic        inst_mis;
    } wb_t;

    // funct3[1] set means word (this also folds the undefined 11x codes into word);
    // otherwise funct3[0] picks half over byte.
    function automatic size_e access_size(input logic [2:0] funct3);
        size_e size;
        if (funct3[1]) begin
            size = SZ_WORD;
        end else if (funct3[0]) begin
            size = SZ_HALF;
        end else begin
            size = SZ_BYTE;
        end
        return size;
    endfunction

endpackage

// File: rtl/stage_mem_align.sv
// mem_align: combinational lane logic for the memory-access stage.
// Ports:
//   funct3     in  3   access size/sign
//   addr_lo    in  2   low effective-address bits
//   st_data    in  32  raw store data (rs2)
//   ld_raw     in  32  raw bus read word
//   sel        out 4   byte enables for the access
//   st_dat     out 32  store data replicated across lanes
//   ld_dat     out 32  selected and sign/zero-extended load value
//   misaligned out 1   access does not fit its natural alignment
module mem_align
    import stage_mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_raw,
    output logic [3:0]  sel,
    output logic [31:0] st_dat,
    output logic [31:0] ld_dat,
    output logic        misaligned
);

    logic [31:0] shifted_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic        sign_en_s;

    // Lane selection of the read word; funct3[2] marks the unsigned loads
    always_comb begin
        shifted_s = ld_raw >> {addr_lo, 3'b000};
        byte_s    = shifted_s[7:0];
        half_s    = addr_lo[1] ? ld_raw[31:16] : ld_raw[15:0];
        sign_en_s = ~funct3[2];
    end

    // Byte enables, store replication, load extension and misalignment per size
    always_comb begin
        sel        = 4'b0000;
        st_dat     = 32'h0000_0000;
        ld_dat     = 32'h0000_0000;
        misaligned = 1'b0;
        case (access_size(funct3))
            SZ_BYTE: begin
                sel        = 4'b0001 << addr_lo;
                st_dat     = {4{st_data[7:0]}};
                ld_dat     = {{24{byte_s[7] & sign_en_s}}, byte_s};
                misaligned = 1'b0;
            end
            SZ_HALF: begin
                sel        = addr_lo[1] ? 4'b1100 : 4'b0011;
                st_dat     = {2{st_data[15:0]}};
                ld_dat     = {{16{half_s[15] & sign_en_s}}, half_s};
                misaligned = addr_lo[0];
            end
            SZ_WORD: begin
                sel        = 4'b1111;
                st_dat     = st_data;
                ld_dat     = ld_raw;
                misaligned = |addr_lo;
            end
            default: begin
                sel        = 4'b0000;
                st_dat     = 32'h0000_0000;
                ld_dat     = 32'h0000_0000;
                misaligned = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/stage_mem.sv
// stage_mem: memory-access pipeline stage feeding write-back.
// Issues loads/stores on a Wishbone-classic data port, aligns load data,
// flags misaligned accesses and registers the whole write-back bundle.
// Ports:
//   clk_i, rst_i (async active-low)
//   execute side : valid_i, pc_i, instruction_i, funct3_i, alu_d_i, st_d_i,
//                  is_ld_mem_i, is_st_mem_i, e_illegal_inst_i, e_inst_addr_mis_i
//   control      : flush_i (kill from write-back), stall_o (hold upstream)
//   data bus     : dport_addr_o, dport_dat_o, dport_sel_o, dport_we_o,
//                  dport_cyc_o, dport_stb_o, dport_dat_i, dport_ack_i
//   write-back   : valid_o, pc_o, instruction_o, funct3_o, alu_d_o, mem_d_o,
//                  mem_addr_o, is_ld_mem_o, e_ld_addr_mis_o, e_st_addr_mis_o,
//                  e_illegal_inst_o, e_inst_addr_mis_o
module stage_mem
    import stage_mem_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instruction_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] alu_d_i,
    input  logic [31:0] st_d_i,
    input  logic        is_ld_mem_i,
    input  logic        is_st_mem_i,
    input  logic        e_illegal_inst_i,
    input  logic        e_inst_addr_mis_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic [31:0] dport_addr_o,
    output logic [31:0] dport_dat_o,
    output logic [3:0]  dport_sel_o,
    output logic        dport_we_o,
    output logic        dport_cyc_o,
    output logic        dport_stb_o,
    input  logic [31:0] dport_dat_i,
    input  logic        dport_ack_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] instruction_o,
    output logic [2:0]  funct3_o,
    output logic [31:0] alu_d_o,
    output logic [31:0] mem_d_o,
    output logic [31:0] mem_addr_o,
    output logic        is_ld_mem_o,
    output logic        e_ld_addr_mis_o,
    output logic        e_st_addr_mis_o,
    output logic        e_illegal_inst_o,
    output logic        e_inst_addr_mis_o
);

    state_e      state_r, next_state_s;
    logic        flush_pend_r;

    // Bus request held stable for the whole cycle
    logic [31:0] bus_addr_r, bus_dat_r;
    logic [3:0]  bus_sel_r;
    logic        bus_we_r, bus_cyc_r;

    // Snapshot of the instruction owning the bus cycle
    logic [31:0] req_pc_r, req_instr_r, req_alu_r;
    logic [2:0]  req_funct3_r;
    logic        req_is_ld_r;

    wb_t         wb_r, wb_next_s;

    logic        is_mem_s, mem_req_s, start_s, done_s, stall_s;
    logic [2:0]  align_funct3_s;
    logic [1:0]  align_addr_lo_s;
    logic [3:0]  align_sel_s;
    logic [31:0] align_st_dat_s, align_ld_dat_s;
    logic        align_mis_s;

    // While busy the aligner decodes the captured request (for load extraction);
    // while idle it decodes the live inputs (for lanes and misalignment).
    always_comb begin
        if (state_r == ST_BUSY) begin
            align_funct3_s  = req_funct3_r;
            align_addr_lo_s = req_alu_r[1:0];
        end else begin
            align_funct3_s  = funct3_i;
            align_addr_lo_s = alu_d_i[1:0];
        end
    end

    mem_align u_mem_align (
        .funct3     (align_funct3_s),
        .addr_lo    (align_addr_lo_s),
        .st_data    (st_d_i),
        .ld_raw     (dport_dat_i),
        .sel        (align_sel_s),
        .st_dat     (align_st_dat_s),
        .ld_dat     (align_ld_dat_s),
        .misaligned (align_mis_s)
    );

    // Decide whether the presented instruction needs a bus cycle
    always_comb begin
        is_mem_s  = is_ld_mem_i | is_st_mem_i;
        mem_req_s = valid_i & is_mem_s & ~align_mis_s & ~e_illegal_inst_i
                  & ~e_inst_addr_mis_i & ~flush_i;
    end

    // Next state, stall and the write-back bundle to register this cycle
    always_comb begin
        next_state_s          = state_r;
        start_s               = 1'b0;
        done_s                = 1'b0;
        stall_s               = 1'b0;
        wb_next_s             = '0;
        wb_next_s.instruction = NOP_INSTR;
        case (state_r)
            ST_IDLE: begin
                if (mem_req_s) begin
                    next_state_s = ST_BUSY;
                    start_s      = 1'b1;
                    stall_s      = 1'b1;
                end else if (valid_i && !flush_i) begin
                    // Single-cycle pass: non-memory, misaligned or pre-faulted
                    wb_next_s.valid       = 1'b1;
                    wb_next_s.pc          = pc_i;
                    wb_next_s.instruction = instruction_i;
                    wb_next_s.funct3      = funct3_i;
                    wb_next_s.alu_d       = alu_d_i;
                    wb_next_s.mem_d       = 32'h0000_0000;
                    wb_next_s.mem_addr    = alu_d_i;
                    wb_next_s.is_ld       = is_ld_mem_i;
                    wb_next_s.ld_mis      = is_ld_mem_i & align_mis_s;
                    wb_next_s.st_mis      = is_st_mem_i & align_mis_s;
                    wb_next_s.illegal     = e_illegal_inst_i;
                    wb_next_s.inst_mis    = e_inst_addr_mis_i;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (dport_ack_i) begin
                    next_state_s = ST_IDLE;
                    done_s       = 1'b1;
                    // A flush seen at any point of the bus cycle discards the result
                    if (!(flush_pend_r || flush_i)) begin
                        wb_next_s.valid       = 1'b1;
                        wb_next_s.pc          = req_pc_r;
                        wb_next_s.instruction = req_instr_r;
                        wb_next_s.funct3      = req_funct3_r;
                        wb_next_s.alu_d       = req_alu_r;
                        wb_next_s.mem_d       = req_is_ld_r ? align_ld_dat_s : 32'h0000_0000;
                        wb_next_s.mem_addr    = req_alu_r;
                        wb_next_s.is_ld       = req_is_ld_r;
                    end else begin
                        wb_next_s.valid = 1'b0;
                    end
                end else begin
                    stall_s = 1'b1;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Remember a flush that arrives while the bus cycle is still in flight
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            flush_pend_r <= 1'b0;
        end else if (done_s || start_s) begin
            flush_pend_r <= 1'b0;
        end else if (state_r == ST_BUSY && flush_i) begin
            flush_pend_r <= 1'b1;
        end else begin
            flush_pend_r <= flush_pend_r;
        end
    end

    // Bus request registers: loaded on start, cyc/we dropped after ack
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bus_addr_r <= 32'h0000_0000;
            bus_dat_r  <= 32'h0000_0000;
            bus_sel_r  <= 4'b0000;
            bus_we_r   <= 1'b0;
            bus_cyc_r  <= 1'b0;
        end else if (start_s) begin
            bus_addr_r <= {alu_d_i[31:2], 2'b00};
            bus_dat_r  <= align_st_dat_s;
            bus_sel_r  <= align_sel_s;
            bus_we_r   <= is_st_mem_i;
            bus_cyc_r  <= 1'b1;
        end else if (done_s) begin
            bus_we_r   <= 1'b0;
            bus_cyc_r  <= 1'b0;
        end else begin
            bus_cyc_r  <= bus_cyc_r;
        end
    end

    // Capture the owning instruction so upstream changes cannot corrupt the result
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            req_pc_r     <= 32'h0000_0000;
            req_instr_r  <= 32'h0000_0000;
            req_alu_r    <= 32'h0000_0000;
            req_funct3_r <= 3'b000;
            req_is_ld_r  <= 1'b0;
        end else if (start_s) begin
            req_pc_r     <= pc_i;
            req_instr_r  <= instruction_i;
            req_alu_r    <= alu_d_i;
            req_funct3_r <= funct3_i;
            req_is_ld_r  <= is_ld_mem_i;
        end else begin
            req_is_ld_r  <= req_is_ld_r;
        end
    end

    // Write-back output register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wb_r             <= '0;
            wb_r.instruction <= NOP_INSTR;
        end else begin
            wb_r <= wb_next_s;
        end
    end

    assign stall_o           = stall_s;
    assign dport_addr_o      = bus_addr_r;
    assign dport_dat_o       = bus_dat_r;
    assign dport_sel_o       = bus_sel_r;
    assign dport_we_o        = bus_we_r;
    assign dport_cyc_o       = bus_cyc_r;
    assign dport_stb_o       = bus_cyc_r;

    assign valid_o           = wb_r.valid;
    assign pc_o              = wb_r.pc;
    assign instruction_o     = wb_r.instruction;
    assign funct3_o          = wb_r.funct3;
    assign alu_d_o           = wb_r.alu_d;
    assign mem_d_o           = wb_r.mem_d;
    assign mem_addr_o        = wb_r.mem_addr;
    assign is_ld_mem_o       = wb_r.is_ld;
    assign e_ld_addr_mis_o   = wb_r.ld_mis;
    assign e_st_addr_mis_o   = wb_r.st_mis;
    assign e_illegal_inst_o  = wb_r.illegal;
    assign e_inst_addr_mis_o = wb_r.inst_mis;

endmodule

// File: tb/tb_stage_mem.sv
// Self-checking bench for stage_mem: table of single-cycle vectors,
// hand-written multi-cycle sequences, then randomized traffic against
// a byte-level reference memory and an arithmetic load/store model.
module tb_stage_mem;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [31:0] pc_i, instruction_i, alu_d_i, st_d_i;
    logic [2:0]  funct3_i;
    logic        is_ld_mem_i, is_st_mem_i, e_illegal_inst_i, e_inst_addr_mis_i, flush_i;
    logic        stall_o;
    logic [31:0] dport_addr_o, dport_dat_o, dport_dat_i;
    logic [3:0]  dport_sel_o;
    logic        dport_we_o, dport_cyc_o, dport_stb_o, dport_ack_i;
    logic        valid_o;
    logic [31:0] pc_o, instruction_o, alu_d_o, mem_d_o, mem_addr_o;
    logic [2:0]  funct3_o;
    logic        is_ld_mem_o, e_ld_addr_mis_o, e_st_addr_mis_o, e_illegal_inst_o, e_inst_addr_mis_o;

    stage_mem dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .pc_i(pc_i),
        .instruction_i(instruction_i), .funct3_i(funct3_i), .alu_d_i(alu_d_i),
        .st_d_i(st_d_i), .is_ld_mem_i(is_ld_mem_i), .is_st_mem_i(is_st_mem_i),
        .e_illegal_inst_i(e_illegal_inst_i), .e_inst_addr_mis_i(e_inst_addr_mis_i),
        .flush_i(flush_i), .stall_o(stall_o), .dport_addr_o(dport_addr_o),
        .dport_dat_o(dport_dat_o), .dport_sel_o(dport_sel_o), .dport_we_o(dport_we_o),
        .dport_cyc_o(dport_cyc_o), .dport_stb_o(dport_stb_o), .dport_dat_i(dport_dat_i),
        .dport_ack_i(dport_ack_i), .valid_o(valid_o), .pc_o(pc_o),
        .instruction_o(instruction_o), .funct3_o(funct3_o), .alu_d_o(alu_d_o),
        .mem_d_o(mem_d_o), .mem_addr_o(mem_addr_o), .is_ld_mem_o(is_ld_mem_o),
        .e_ld_addr_mis_o(e_ld_addr_mis_o), .e_st_addr_mis_o(e_st_addr_mis_o),
        .e_illegal_inst_o(e_illegal_inst_o), .e_inst_addr_mis_o(e_inst_addr_mis_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        valid;
        logic [31:0] pc, instr;
        logic [2:0]  f3;
        logic [31:0] addr, st_d;
        logic        is_ld, is_st, ill, imis, flush;
    } op_t;

    typedef struct {
        logic        bus, valid;
        logic [31:0] instr, mem_d, mem_addr, dat;
        logic [3:0]  sel;
        logic        ld_mis, st_mis;
    } exp_t;

    typedef struct {
        op_t         op;
        logic        exp_valid;
        logic [31:0] exp_instr, exp_mem_addr;
        logic        exp_ld_mis, exp_st_mis, exp_ill;
    } vec_t;

    logic [31:0] bus_mem [256];
    logic [31:0] ref_mem [256];
    int n_checks = 0;
    int n_fail   = 0;

    // Observations of the last bus cycle
    int          seen_stalls, seen_cycs;
    logic [31:0] seen_addr, seen_dat;
    logic [3:0]  seen_sel;
    logic        seen_we, seen_stable, seen_timeout;

    logic [2:0] ld_codes [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0] st_codes [3] = '{3'b000, 3'b001, 3'b010};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic op_t mk_op(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                                  input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] st_d,
                                  input logic ld, input logic st, input logic ill, input logic imis,
                                  input logic fl);
        op_t o;
        o.valid = v; o.pc = pc; o.instr = instr; o.f3 = f3; o.addr = addr; o.st_d = st_d;
        o.is_ld = ld; o.is_st = st; o.ill = ill; o.imis = imis; o.flush = fl;
        return o;
    endfunction

    // Reference model: sizes, alignment, lanes and extension by plain arithmetic
    function automatic exp_t predict(input op_t op);
        exp_t e;
        int size;
        longint unsigned w, v, mask;
        e.bus = 1'b0; e.valid = 1'b0; e.instr = NOP; e.mem_d = 32'h0; e.mem_addr = 32'h0;
        e.dat = 32'h0; e.sel = 4'h0; e.ld_mis = 1'b0; e.st_mis = 1'b0;
        if (!op.valid || op.flush) return e;
        size = op.f3[1] ? 4 : (op.f3[0] ? 2 : 1);
        e.valid    = 1'b1;
        e.instr    = op.instr;
        e.mem_addr = op.addr;
        e.ld_mis   = op.is_ld && (op.addr % size != 0);
        e.st_mis   = op.is_st && (op.addr % size != 0);
        e.bus      = (op.is_ld || op.is_st) && (op.addr % size == 0) && !op.ill && !op.imis;
        mask = (64'd1 << (8 * size)) - 64'd1;
        if (e.bus && op.is_ld) begin
            w = 64'(ref_mem[op.addr[9:2]]);
            v = (w >> (8 * (op.addr % 4))) & mask;
            if (!op.f3[2] && size < 4 && (((v >> (8 * size - 1)) & 64'd1) == 64'd1))
                v = v | (64'h0000_0000_FFFF_FFFF & ~mask);
            e.mem_d = v[31:0];
        end
        if (e.bus && op.is_st) begin
            e.sel = 4'(((1 << size) - 1) << (op.addr % 4));
            if (size == 1)      e.dat = 32'(op.st_d[7:0]) * 32'h0101_0101;
            else if (size == 2) e.dat = 32'(op.st_d[15:0]) * 32'h0001_0001;
            else                e.dat = op.st_d;
        end
        return e;
    endfunction

    task automatic ref_store(input logic [31:0] addr, input logic [3:0] sel, input logic [31:0] dat);
        for (int i = 0; i < 4; i++)
            if (sel[i]) ref_mem[addr[9:2]][8*i +: 8] = dat[8*i +: 8];
    endtask

    // Present one instruction and act as bus slave until the stage stops stalling
    task automatic run_op(input op_t op, input int waits, input int flush_at);
        int k;
        logic done;
        @(negedge clk_i);
        valid_i = op.valid; pc_i = op.pc; instruction_i = op.instr; funct3_i = op.f3;
        alu_d_i = op.addr; st_d_i = op.st_d; is_ld_mem_i = op.is_ld; is_st_mem_i = op.is_st;
        e_illegal_inst_i = op.ill; e_inst_addr_mis_i = op.imis; flush_i = op.flush;
        dport_ack_i = 1'b0;
        seen_stalls = 0; seen_cycs = 0; seen_stable = 1'b1; seen_timeout = 1'b1;
        seen_addr = 32'h0; seen_dat = 32'h0; seen_sel = 4'h0; seen_we = 1'b0;
        for (int c = 0; c < 64; c++) begin
            #1;
            if (dport_cyc_o) begin
                k = seen_cycs;
                if (k == 0) begin
                    seen_addr = dport_addr_o; seen_dat = dport_dat_o;
                    seen_sel = dport_sel_o; seen_we = dport_we_o;
                end else if (dport_addr_o !== seen_addr || dport_dat_o !== seen_dat ||
                             dport_sel_o !== seen_sel || dport_we_o !== seen_we ||
                             dport_stb_o !== 1'b1) begin
                    seen_stable = 1'b0;
                end
                seen_cycs++;
                flush_i = (k == flush_at);
                if (k == waits) begin
                    dport_ack_i = 1'b1;
                    dport_dat_i = bus_mem[dport_addr_o[9:2]];
                    if (dport_we_o)
                        for (int i = 0; i < 4; i++)
                            if (dport_sel_o[i]) bus_mem[dport_addr_o[9:2]][8*i +: 8] = dport_dat_o[8*i +: 8];
                end
            end
            #1;
            if (stall_o) seen_stalls++;
            done = !stall_o;
            @(posedge clk_i);
            if (done) begin
                seen_timeout = 1'b0;
                break;
            end
            @(negedge clk_i);
            dport_ack_i = 1'b0;
        end
        #2;
        dport_ack_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0;
        is_ld_mem_i = 1'b0; is_st_mem_i = 1'b0;
    endtask

    // Run one instruction and compare everything the model predicts
    task automatic check_op(input string tag, input op_t op, input int waits, input int flush_at);
        exp_t e;
        logic flushed, ev;
        int n_bus;
        e = predict(op);
        run_op(op, waits, flush_at);
        if (e.bus && op.is_st) ref_store(op.addr, e.sel, e.dat);
        flushed = e.bus && (flush_at >= 0) && (flush_at <= waits);
        ev = e.valid && !flushed;
        n_bus = e.bus ? waits + 1 : 0;
        chk({tag, ".timeout"}, 32'(seen_timeout), 32'd0);
        chk({tag, ".stalls"}, seen_stalls, n_bus);
        chk({tag, ".cyc_cycles"}, seen_cycs, n_bus);
        chk({tag, ".valid"}, 32'(valid_o), 32'(ev));
        chk({tag, ".instr"}, instruction_o, ev ? e.instr : NOP);
        if (ev) begin
            chk({tag, ".pc"}, pc_o, op.pc);
            chk({tag, ".alu"}, alu_d_o, op.addr);
            chk({tag, ".funct3"}, 32'(funct3_o), 32'(op.f3));
            chk({tag, ".mem_addr"}, mem_addr_o, e.mem_addr);
            chk({tag, ".mem_d"}, mem_d_o, e.mem_d);
            chk({tag, ".is_ld"}, 32'(is_ld_mem_o), 32'(op.is_ld));
            chk({tag, ".ld_mis"}, 32'(e_ld_addr_mis_o), 32'(e.ld_mis));
            chk({tag, ".st_mis"}, 32'(e_st_addr_mis_o), 32'(e.st_mis));
            chk({tag, ".ill"}, 32'(e_illegal_inst_o), 32'(op.ill));
            chk({tag, ".imis"}, 32'(e_inst_addr_mis_o), 32'(op.imis));
        end
        if (e.bus) begin
            chk({tag, ".bus_addr"}, seen_addr, {op.addr[31:2], 2'b00});
            chk({tag, ".bus_stable"}, 32'(seen_stable), 32'd1);
            chk({tag, ".we"}, 32'(seen_we), 32'(op.is_st));
            if (op.is_st) begin
                chk({tag, ".sel"}, 32'(seen_sel), 32'(e.sel));
                chk({tag, ".dat"}, seen_dat, e.dat);
            end
        end
    endtask

    vec_t vecs [7];

    initial begin
        op_t op;
        int kind, waits, flush_at;

        // Single-cycle vectors: {op, valid, instruction, mem_addr, ld_mis, st_mis, illegal}
        vecs[0] = '{mk_op(1, 32'h1000, 32'h0020_81B3, 3'b000, 32'h1234_5678, 32'h0, 0, 0, 0, 0, 0), 1, 32'h0020_81B3, 32'h1234_5678, 0, 0, 0};
        vecs[1] = '{mk_op(1, 32'h1004, 32'h0000_A103, 3'b010, 32'h0000_0101, 32'h0, 1, 0, 0, 0, 0), 1, 32'h0000_A103, 32'h0000_0101, 1, 0, 0};
        vecs[2] = '{mk_op(1, 32'h1008, 32'h0020_91A3, 3'b001, 32'h0000_0203, 32'h1, 0, 1, 0, 0, 0), 1, 32'h0020_91A3, 32'h0000_0203, 0, 1, 0};
        vecs[3] = '{mk_op(0, 32'h100C, 32'h0000_2083, 3'b010, 32'h0000_0100, 32'h0, 1, 0, 0, 0, 0), 0, NOP, 32'h0, 0, 0, 0};
        vecs[4] = '{mk_op(1, 32'h1010, 32'h0000_2083, 3'b010, 32'h0000_0100, 32'h0, 1, 0, 0, 0, 1), 0, NOP, 32'h0, 0, 0, 0};
        vecs[5] = '{mk_op(1, 32'h1014, 32'hFFFF_FFFF, 3'b010, 32'h0000_0104, 32'h0, 1, 0, 1, 0, 0), 1, 32'hFFFF_FFFF, 32'h0000_0104, 0, 0, 1};
        vecs[6] = '{mk_op(1, 32'h1018, 32'h0000_1083, 3'b001, 32'h0000_0105, 32'h0, 1, 0, 0, 0, 0), 1, 32'h0000_1083, 32'h0000_0105, 1, 0, 0};

        for (int i = 0; i < 256; i++) begin
            bus_mem[i] = $urandom;
            ref_mem[i] = bus_mem[i];
        end

        rst_i = 1'b0; valid_i = 1'b0; pc_i = 32'h0; instruction_i = 32'h0; funct3_i = 3'b000;
        alu_d_i = 32'h0; st_d_i = 32'h0; is_ld_mem_i = 1'b0; is_st_mem_i = 1'b0;
        e_illegal_inst_i = 1'b0; e_inst_addr_mis_i = 1'b0; flush_i = 1'b0;
        dport_dat_i = 32'h0; dport_ack_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst.valid", 32'(valid_o), 32'd0);
        chk("rst.instr", instruction_o, NOP);
        chk("rst.pc", pc_o, 32'h0);
        chk("rst.mem_d", mem_d_o, 32'h0);
        chk("rst.cyc", 32'(dport_cyc_o), 32'd0);
        chk("rst.stb", 32'(dport_stb_o), 32'd0);
        chk("rst.we", 32'(dport_we_o), 32'd0);
        rst_i = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].op, 0, -1);
            chk($sformatf("vec%0d.stalls", i), seen_stalls, 0);
            chk($sformatf("vec%0d.cyc", i), seen_cycs, 0);
            chk($sformatf("vec%0d.valid", i), 32'(valid_o), 32'(vecs[i].exp_valid));
            chk($sformatf("vec%0d.instr", i), instruction_o, vecs[i].exp_instr);
            if (vecs[i].exp_valid) begin
                chk($sformatf("vec%0d.mem_addr", i), mem_addr_o, vecs[i].exp_mem_addr);
                chk($sformatf("vec%0d.ld_mis", i), 32'(e_ld_addr_mis_o), 32'(vecs[i].exp_ld_mis));
                chk($sformatf("vec%0d.st_mis", i), 32'(e_st_addr_mis_o), 32'(vecs[i].exp_st_mis));
                chk($sformatf("vec%0d.ill", i), 32'(e_illegal_inst_o), 32'(vecs[i].exp_ill));
            end
        end

        // LW with two wait states
        bus_mem[64] = 32'hDEAD_BEEF; ref_mem[64] = 32'hDEAD_BEEF;
        check_op("lw_wait", mk_op(1, 32'h2000, 32'h1000_2083, 3'b010, 32'h100, 32'h0, 1, 0, 0, 0, 0), 2, -1);
        chk("lw_wait.stall3", seen_stalls, 3);
        chk("lw_wait.data", mem_d_o, 32'hDEAD_BEEF);

        // Byte loads, signed and unsigned, from the top lane
        bus_mem[64] = 32'h80FF_7F01; ref_mem[64] = 32'h80FF_7F01;
        check_op("lb", mk_op(1, 32'h2004, 32'h1030_0083, 3'b000, 32'h103, 32'h0, 1, 0, 0, 0, 0), 0, -1);
        chk("lb.data", mem_d_o, 32'hFFFF_FF80);
        check_op("lbu", mk_op(1, 32'h2008, 32'h1030_4083, 3'b100, 32'h103, 32'h0, 1, 0, 0, 0, 0), 1, -1);
        chk("lbu.data", mem_d_o, 32'h0000_0080);

        // Store lane checks
        check_op("sh", mk_op(1, 32'h200C, 32'h2020_1123, 3'b001, 32'h202, 32'h0000_ABCD, 0, 1, 0, 0, 0), 1, -1);
        chk("sh.sel", 32'(seen_sel), 32'b1100);
        chk("sh.dat", seen_dat, 32'hABCD_ABCD);
        chk("sh.we", 32'(seen_we), 32'd1);
        check_op("sb", mk_op(1, 32'h2010, 32'h2010_00A3, 3'b000, 32'h201, 32'h0000_0055, 0, 1, 0, 0, 0), 0, -1);
        chk("sb.sel", 32'(seen_sel), 32'b0010);

        // Flush pulsed mid-cycle: bus completes, result discarded, next op passes
        check_op("flush_busy", mk_op(1, 32'h2014, 32'h1000_2083, 3'b010, 32'h100, 32'h0, 1, 0, 0, 0, 0), 3, 1);
        chk("flush_busy.cyc_held", seen_cycs, 4);
        chk("flush_busy.valid", 32'(valid_o), 32'd0);
        check_op("after_flush", mk_op(1, 32'h2018, 32'h0020_81B3, 3'b000, 32'h55, 32'h0, 0, 0, 0, 0, 0), 0, -1);
        chk("after_flush.valid", 32'(valid_o), 32'd1);

        // Reset while a store is on the bus
        @(negedge clk_i);
        valid_i = 1'b1; pc_i = 32'h3000; instruction_i = 32'h0020_2023; funct3_i = 3'b010;
        alu_d_i = 32'h300; st_d_i = 32'h1234_5678; is_st_mem_i = 1'b1; dport_ack_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        #1;
        chk("rst_busy.cyc_before", 32'(dport_cyc_o), 32'd1);
        rst_i = 1'b0;
        #1;
        chk("rst_busy.cyc", 32'(dport_cyc_o), 32'd0);
        chk("rst_busy.stb", 32'(dport_stb_o), 32'd0);
        chk("rst_busy.we", 32'(dport_we_o), 32'd0);
        chk("rst_busy.instr", instruction_o, NOP);
        valid_i = 1'b0; is_st_mem_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        check_op("after_rst", mk_op(1, 32'h3004, 32'h0040_8133, 3'b000, 32'h77, 32'h0, 0, 0, 0, 0, 0), 0, -1);

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            kind = $urandom_range(0, 2);
            op = mk_op(($urandom_range(0, 15) != 0), $urandom & 32'hFFFF_FFFC, $urandom,
                       3'($urandom_range(0, 7)), $urandom, $urandom, 0, 0, 0, 0,
                       ($urandom_range(0, 15) == 0));
            if (kind == 1) begin
                op.is_ld = 1'b1; op.f3 = ld_codes[$urandom_range(0, 4)]; op.addr = $urandom_range(0, 1023);
            end else if (kind == 2) begin
                op.is_st = 1'b1; op.f3 = st_codes[$urandom_range(0, 2)]; op.addr = $urandom_range(0, 1023);
            end else begin
                op.ill  = ($urandom_range(0, 15) == 0);
                op.imis = ($urandom_range(0, 15) == 0);
            end
            waits = $urandom_range(0, 3);
            flush_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, waits) : -1;
            check_op($sformatf("rnd%0d", n), op, waits, flush_at);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
